// File: rtl/noc_packetizer.sv
// Network-interface packetizer: turns a packet request plus a body-word stream into
// labelled, VC-tagged flits, with per-VC credit flow control and round-robin VC choice.
module noc_packetizer #(
   parameter int  MESH_SIZE_X       = 5,
   parameter int  MESH_SIZE_Y       = 5,
   parameter int  LOCAL_NUM         = 5,
   parameter int  VC_NUM            = 4,
   parameter int  HEAD_PAYLOAD_SIZE = 128,
   parameter int  BUFFER_DEPTH      = 8,
   parameter int  LEN_W             = 4,
   localparam int X_W    = $clog2(MESH_SIZE_X),
   localparam int Y_W    = $clog2(MESH_SIZE_Y),
   localparam int L_W    = $clog2(LOCAL_NUM),
   localparam int VC_W   = $clog2(VC_NUM),
   localparam int CR_W   = $clog2(BUFFER_DEPTH + 1),
   localparam int DATA_W = X_W + Y_W + L_W + HEAD_PAYLOAD_SIZE,
   localparam int FLIT_W = 2 + VC_W + DATA_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         pkt_valid_i,
   output logic                         pkt_ready_o,
   input  logic [X_W-1:0]               pkt_x_i,
   input  logic [Y_W-1:0]               pkt_y_i,
   input  logic [L_W-1:0]               pkt_l_i,
   input  logic [HEAD_PAYLOAD_SIZE-1:0] pkt_head_pl_i,
   input  logic [LEN_W-1:0]             pkt_len_i,
   input  logic                         bt_valid_i,
   output logic                         bt_ready_o,
   input  logic [DATA_W-1:0]            bt_data_i,
   output logic                         flit_valid_o,
   output logic [FLIT_W-1:0]            flit_o,
   input  logic                         credit_valid_i,
   input  logic [VC_W-1:0]              credit_vc_i,
   output logic                         err_o
);

   localparam logic [1:0] LBL_HEAD     = 2'd0;
   localparam logic [1:0] LBL_BODY     = 2'd1;
   localparam logic [1:0] LBL_TAIL     = 2'd2;
   localparam logic [1:0] LBL_HEADTAIL = 2'd3;

   typedef enum logic {S_IDLE, S_BODY} state_t;

   state_t              r_state;
   logic [CR_W-1:0]     r_cnt [VC_NUM];
   logic [VC_W-1:0]     r_rr_ptr;
   logic [VC_W-1:0]     r_cur_vc;
   logic [LEN_W-1:0]    r_remaining;
   logic                r_flit_valid;
   logic [FLIT_W-1:0]   r_flit;
   logic                r_err;

   logic                w_any_credit;
   logic [VC_W-1:0]     w_alloc_vc;
   logic [VC_W-1:0]     w_cand;
   logic                w_pkt_acc;
   logic                w_bt_acc;
   logic                w_send;
   logic [VC_W-1:0]     w_send_vc;
   logic [VC_NUM-1:0]   w_ret;
   logic [VC_NUM-1:0]   w_take;
   logic [1:0]          w_head_lbl;
   logic [1:0]          w_body_lbl;

   function automatic logic [VC_W-1:0] vc_wrap(input logic [VC_W-1:0] base, input int offs);
      int sum;
      sum = int'(base) + offs;
      return VC_W'(sum % VC_NUM);
   endfunction

   always_comb begin
      w_any_credit = 1'b0;
      for (int v = 0; v < VC_NUM; v++) begin
         if (r_cnt[v] != '0) w_any_credit = 1'b1;
      end
   end

   // Scan farthest-first so the nearest VC after rr_ptr holding credit wins.
   always_comb begin
      w_alloc_vc = r_rr_ptr;
      w_cand     = '0;
      for (int k = VC_NUM; k >= 1; k--) begin
         w_cand = vc_wrap(r_rr_ptr, k);
         if (r_cnt[w_cand] != '0) w_alloc_vc = w_cand;
      end
   end

   assign pkt_ready_o = (r_state == S_IDLE) && w_any_credit;
   assign bt_ready_o  = (r_state == S_BODY) && (r_cnt[r_cur_vc] != '0);
   assign w_pkt_acc   = pkt_valid_i && pkt_ready_o;
   assign w_bt_acc    = bt_valid_i && bt_ready_o;
   assign w_send      = w_pkt_acc || w_bt_acc;
   assign w_send_vc   = w_pkt_acc ? w_alloc_vc : r_cur_vc;
   assign w_head_lbl  = (pkt_len_i == '0) ? LBL_HEADTAIL : LBL_HEAD;
   assign w_body_lbl  = (r_remaining == LEN_W'(1)) ? LBL_TAIL : LBL_BODY;

   always_comb begin
      for (int v = 0; v < VC_NUM; v++) begin
         w_ret[v]  = credit_valid_i && (credit_vc_i == VC_W'(v));
         w_take[v] = w_send && (w_send_vc == VC_W'(v));
      end
   end

   // A return into a full counter is held rather than wrapped, and flagged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int v = 0; v < VC_NUM; v++) r_cnt[v] <= CR_W'(BUFFER_DEPTH);
         r_err <= 1'b0;
      end else begin
         for (int v = 0; v < VC_NUM; v++) begin
            if (w_ret[v] && !w_take[v]) begin
               if (r_cnt[v] == CR_W'(BUFFER_DEPTH)) r_err <= 1'b1;
               else                                 r_cnt[v] <= r_cnt[v] + CR_W'(1);
            end else if (w_take[v] && !w_ret[v]) begin
               r_cnt[v] <= r_cnt[v] - CR_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_rr_ptr     <= VC_W'(VC_NUM - 1);
         r_cur_vc     <= '0;
         r_remaining  <= '0;
         r_flit_valid <= 1'b0;
         r_flit       <= '0;
      end else begin
         r_flit_valid <= w_send;
         case (r_state)
            S_IDLE: begin
               if (w_pkt_acc) begin
                  r_flit      <= {w_head_lbl, w_alloc_vc, pkt_x_i, pkt_y_i, pkt_l_i, pkt_head_pl_i};
                  r_rr_ptr    <= w_alloc_vc;
                  r_cur_vc    <= w_alloc_vc;
                  r_remaining <= pkt_len_i;
                  if (pkt_len_i != '0) r_state <= S_BODY;
               end
            end
            S_BODY: begin
               if (w_bt_acc) begin
                  r_flit      <= {w_body_lbl, r_cur_vc, bt_data_i};
                  r_remaining <= r_remaining - LEN_W'(1);
                  if (r_remaining == LEN_W'(1)) r_state <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign flit_valid_o = r_flit_valid;
   assign flit_o       = r_flit;
   assign err_o        = r_err;

endmodule

// File: tb/tb_noc_packetizer.sv
// Bench for noc_packetizer: directed table, multi-cycle corner sequences, and a
// randomized run checked against a credit/packet reference model.
module tb_noc_packetizer;

   localparam int MX = 5, MY = 5, LN = 5, VCN = 4, HP = 128, DEPTH = 8, LEN_W = 4;
   localparam int X_W    = $clog2(MX);
   localparam int Y_W    = $clog2(MY);
   localparam int L_W    = $clog2(LN);
   localparam int VC_W   = $clog2(VCN);
   localparam int DATA_W = X_W + Y_W + L_W + HP;
   localparam int FLIT_W = 2 + VC_W + DATA_W;
   localparam logic [1:0] LB_HEAD = 2'd0, LB_BODY = 2'd1, LB_TAIL = 2'd2, LB_HT = 2'd3;

   logic              clk;
   logic              rst;
   logic              pkt_valid_i;
   logic              pkt_ready_o;
   logic [X_W-1:0]    pkt_x_i;
   logic [Y_W-1:0]    pkt_y_i;
   logic [L_W-1:0]    pkt_l_i;
   logic [HP-1:0]     pkt_head_pl_i;
   logic [LEN_W-1:0]  pkt_len_i;
   logic              bt_valid_i;
   logic              bt_ready_o;
   logic [DATA_W-1:0] bt_data_i;
   logic              flit_valid_o;
   logic [FLIT_W-1:0] flit_o;
   logic              credit_valid_i;
   logic [VC_W-1:0]   credit_vc_i;
   logic              err_o;

   int n_cmp = 0;
   int n_bad = 0;

   noc_packetizer #(
      .MESH_SIZE_X(MX), .MESH_SIZE_Y(MY), .LOCAL_NUM(LN), .VC_NUM(VCN),
      .HEAD_PAYLOAD_SIZE(HP), .BUFFER_DEPTH(DEPTH), .LEN_W(LEN_W)
   ) dut (
      .clk(clk), .rst(rst),
      .pkt_valid_i(pkt_valid_i), .pkt_ready_o(pkt_ready_o),
      .pkt_x_i(pkt_x_i), .pkt_y_i(pkt_y_i), .pkt_l_i(pkt_l_i),
      .pkt_head_pl_i(pkt_head_pl_i), .pkt_len_i(pkt_len_i),
      .bt_valid_i(bt_valid_i), .bt_ready_o(bt_ready_o), .bt_data_i(bt_data_i),
      .flit_valid_o(flit_valid_o), .flit_o(flit_o),
      .credit_valid_i(credit_valid_i), .credit_vc_i(credit_vc_i),
      .err_o(err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic              pv;
      int                px, py, pl;
      logic [7:0]        ppl;
      int                plen;
      logic              bv;
      logic [7:0]        bd;
      logic              e_prdy, e_brdy, e_fv;
      logic [FLIT_W-1:0] e_flit;
   } vec_t;

   vec_t tbl[7];

   function automatic logic [DATA_W-1:0] head_data(input int x, input int y, input int l,
                                                   input logic [HP-1:0] pl);
      return {X_W'(x), Y_W'(y), L_W'(l), pl};
   endfunction

   function automatic logic [FLIT_W-1:0] mk_flit(input logic [1:0] lab, input int vc,
                                                 input logic [DATA_W-1:0] d);
      return {lab, VC_W'(vc), d};
   endfunction

   task automatic chk1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0b, expected %0b", name, act, exp);
      end
   endtask

   task automatic chkf(input string name, input logic [FLIT_W-1:0] act, input logic [FLIT_W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      pkt_valid_i    = 1'b0;
      bt_valid_i     = 1'b0;
      credit_valid_i = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive_idle();
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   // Packet with 8 flits after the head; n_ok of the 8 body/tail words are expected to go out.
   task automatic pkt8(input int vc, input int cr_vc, input int n_ok);
      pkt_valid_i    = 1'b1;
      pkt_x_i        = X_W'(2);
      pkt_y_i        = Y_W'(0);
      pkt_l_i        = L_W'(3);
      pkt_head_pl_i  = HP'(vc + 64);
      pkt_len_i      = LEN_W'(8);
      credit_valid_i = (cr_vc >= 0);
      credit_vc_i    = VC_W'((cr_vc < 0) ? 0 : cr_vc);
      #1 chk1("pkt8 pkt_ready", pkt_ready_o, 1'b1);
      tick();
      pkt_valid_i    = 1'b0;
      credit_valid_i = 1'b0;
      chk1("pkt8 head valid", flit_valid_o, 1'b1);
      chkf("pkt8 head flit", flit_o, mk_flit(LB_HEAD, vc, head_data(2, 0, 3, HP'(vc + 64))));
      for (int k = 1; k <= 8; k++) begin
         bt_valid_i = 1'b1;
         bt_data_i  = DATA_W'(k);
         #1 chk1("pkt8 bt_ready", bt_ready_o, k <= n_ok);
         tick();
         chk1("pkt8 flit_valid", flit_valid_o, k <= n_ok);
         if (k <= n_ok)
            chkf("pkt8 body/tail", flit_o, mk_flit((k == 8) ? LB_TAIL : LB_BODY, vc, DATA_W'(k)));
      end
      bt_valid_i = 1'b0;
   endtask

   task automatic run_random(input int ncyc);
      int cr[VCN];
      int rr, cur, rem, v, cvc, x, y, l, len;
      bit busy, merr, e_prdy, e_brdy, e_fv, any;
      logic [FLIT_W-1:0] e_flit;
      logic [DATA_W-1:0] d;
      logic [HP-1:0]     pl;
      for (int i = 0; i < VCN; i++) cr[i] = DEPTH;
      rr = VCN - 1; cur = 0; rem = 0; busy = 0; merr = 0;
      for (int c = 0; c < ncyc; c++) begin
         x   = $urandom_range(0, MX - 1);
         y   = $urandom_range(0, MY - 1);
         l   = $urandom_range(0, LN - 1);
         len = ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 4);
         pl  = HP'({$urandom, $urandom, $urandom, $urandom});
         d   = DATA_W'({$urandom, $urandom, $urandom, $urandom, $urandom});
         cvc = $urandom_range(0, VCN - 1);
         pkt_valid_i    = ($urandom_range(0, 99) < 35);
         pkt_x_i        = X_W'(x);
         pkt_y_i        = Y_W'(y);
         pkt_l_i        = L_W'(l);
         pkt_head_pl_i  = pl;
         pkt_len_i      = LEN_W'(len);
         bt_valid_i     = ($urandom_range(0, 99) < 70);
         bt_data_i      = d;
         credit_valid_i = ($urandom_range(0, 99) < 45) && (cr[cvc] < DEPTH);
         credit_vc_i    = VC_W'(cvc);
         #1;
         any = 0;
         for (int i = 0; i < VCN; i++) if (cr[i] > 0) any = 1;
         e_prdy = !busy && any;
         e_brdy = busy && (cr[cur] > 0);
         chk1("rand pkt_ready", pkt_ready_o, e_prdy);
         chk1("rand bt_ready", bt_ready_o, e_brdy);
         e_fv = 0;
         e_flit = '0;
         if (pkt_valid_i && e_prdy) begin
            v = -1;
            for (int k = 1; k <= VCN; k++)
               if (v < 0 && cr[(rr + k) % VCN] > 0) v = (rr + k) % VCN;
            e_fv   = 1;
            e_flit = mk_flit((len == 0) ? LB_HT : LB_HEAD, v, head_data(x, y, l, pl));
            cr[v]--;
            rr = v; cur = v; rem = len; busy = (len != 0);
         end else if (bt_valid_i && e_brdy) begin
            e_fv   = 1;
            e_flit = mk_flit((rem == 1) ? LB_TAIL : LB_BODY, cur, d);
            cr[cur]--;
            rem--;
            if (rem == 0) busy = 0;
         end
         if (credit_valid_i) begin
            if (cr[cvc] == DEPTH) merr = 1;
            else                  cr[cvc]++;
         end
         tick();
         chk1("rand flit_valid", flit_valid_o, e_fv);
         if (e_fv) chkf("rand flit", flit_o, e_flit);
         chk1("rand err", err_o, merr);
      end
      drive_idle();
   endtask

   initial begin
      tbl[0] = '{1'b1, 3, 2, 1, 8'hA5, 0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1,
                 mk_flit(LB_HT, 0, head_data(3, 2, 1, HP'(8'hA5)))};
      tbl[1] = '{1'b1, 1, 1, 0, 8'h5A, 3, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1,
                 mk_flit(LB_HEAD, 1, head_data(1, 1, 0, HP'(8'h5A)))};
      tbl[2] = '{1'b1, 4, 4, 4, 8'hFF, 2, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1,
                 mk_flit(LB_BODY, 1, DATA_W'(8'h11))};
      tbl[3] = '{1'b0, 0, 0, 0, 8'h00, 0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1,
                 mk_flit(LB_BODY, 1, DATA_W'(8'h22))};
      tbl[4] = '{1'b0, 0, 0, 0, 8'h00, 0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b1,
                 mk_flit(LB_TAIL, 1, DATA_W'(8'h33))};
      tbl[5] = '{1'b1, 0, 4, 4, 8'h3C, 0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1,
                 mk_flit(LB_HT, 2, head_data(0, 4, 4, HP'(8'h3C)))};
      tbl[6] = '{1'b0, 0, 0, 0, 8'h00, 0, 1'b1, 8'h99, 1'b1, 1'b0, 1'b0, '0};

      rst = 1'b1;
      drive_idle();
      pkt_x_i = '0; pkt_y_i = '0; pkt_l_i = '0; pkt_head_pl_i = '0; pkt_len_i = '0;
      bt_data_i = '0; credit_vc_i = '0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk1("reset flit_valid", flit_valid_o, 1'b0);
      chkf("reset flit", flit_o, '0);
      chk1("reset err", err_o, 1'b0);
      chk1("reset pkt_ready", pkt_ready_o, 1'b1);
      chk1("reset bt_ready", bt_ready_o, 1'b0);

      for (int i = 0; i < 7; i++) begin
         pkt_valid_i   = tbl[i].pv;
         pkt_x_i       = X_W'(tbl[i].px);
         pkt_y_i       = Y_W'(tbl[i].py);
         pkt_l_i       = L_W'(tbl[i].pl);
         pkt_head_pl_i = HP'(tbl[i].ppl);
         pkt_len_i     = LEN_W'(tbl[i].plen);
         bt_valid_i    = tbl[i].bv;
         bt_data_i     = DATA_W'(tbl[i].bd);
         #1;
         chk1($sformatf("tbl%0d pkt_ready", i), pkt_ready_o, tbl[i].e_prdy);
         chk1($sformatf("tbl%0d bt_ready", i), bt_ready_o, tbl[i].e_brdy);
         tick();
         chk1($sformatf("tbl%0d flit_valid", i), flit_valid_o, tbl[i].e_fv);
         if (tbl[i].e_fv) chkf($sformatf("tbl%0d flit", i), flit_o, tbl[i].e_flit);
      end
      drive_idle();
      chk1("tbl err", err_o, 1'b0);

      // Credit stall on VC0, then one returned credit releases the tail.
      do_reset();
      pkt8(0, -1, 7);
      bt_valid_i     = 1'b1;
      bt_data_i      = DATA_W'(8);
      credit_valid_i = 1'b1;
      credit_vc_i    = VC_W'(0);
      #1 chk1("stall bt_ready same-cycle return", bt_ready_o, 1'b0);
      tick();
      credit_valid_i = 1'b0;
      chk1("stall no flit", flit_valid_o, 1'b0);
      #1 chk1("stall bt_ready after return", bt_ready_o, 1'b1);
      tick();
      bt_valid_i = 1'b0;
      chk1("stall tail valid", flit_valid_o, 1'b1);
      chkf("stall tail flit", flit_o, mk_flit(LB_TAIL, 0, DATA_W'(8)));
      #1 chk1("stall pkt_ready after tail", pkt_ready_o, 1'b1);

      // Head send and credit return on VC1 in the same cycle leave its count at full.
      pkt8(1, 1, 8);
      chk1("simultaneous err", err_o, 1'b0);

      // Overflow on idle VC0: sticky error, count held at full depth.
      do_reset();
      credit_valid_i = 1'b1;
      credit_vc_i    = VC_W'(0);
      #1 chk1("overflow err before", err_o, 1'b0);
      tick();
      credit_valid_i = 1'b0;
      chk1("overflow err set", err_o, 1'b1);
      tick();
      tick();
      chk1("overflow err sticky", err_o, 1'b1);
      pkt8(0, -1, 7);
      chk1("overflow err still set", err_o, 1'b1);
      do_reset();
      chk1("overflow err cleared by rst", err_o, 1'b0);

      // Reset in the middle of a packet.
      pkt_valid_i   = 1'b1;
      pkt_x_i       = X_W'(1);
      pkt_y_i       = Y_W'(2);
      pkt_l_i       = L_W'(3);
      pkt_head_pl_i = HP'(8'h99);
      pkt_len_i     = LEN_W'(5);
      tick();
      pkt_valid_i = 1'b0;
      chkf("midrst head", flit_o, mk_flit(LB_HEAD, 0, head_data(1, 2, 3, HP'(8'h99))));
      for (int k = 1; k <= 2; k++) begin
         bt_valid_i = 1'b1;
         bt_data_i  = DATA_W'(k + 16);
         tick();
         chkf("midrst body", flit_o, mk_flit(LB_BODY, 0, DATA_W'(k + 16)));
      end
      rst = 1'b1;
      #1;
      chk1("midrst flit_valid async", flit_valid_o, 1'b0);
      chk1("midrst pkt_ready", pkt_ready_o, 1'b1);
      chk1("midrst bt_ready", bt_ready_o, 1'b0);
      tick();
      rst = 1'b0;
      #1 chk1("midrst bt_ready after", bt_ready_o, 1'b0);
      tick();
      chk1("midrst no stray tail", flit_valid_o, 1'b0);
      bt_valid_i = 1'b0;
      pkt8(0, -1, 7);

      do_reset();
      run_random(3000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
